// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BIOS/IMEM address generation
// and instruction select for the decode stage.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [11:0] bios_addr_o,
    input  logic [31:0] bios_dout_i,
    output logic [13:0] imem_addr_o,
    input  logic [31:0] imem_dout_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o,
    output logic        misalign_err_o,
    output logic [31:0] fetch_cnt_o
);

    logic [31:0] pc_q, pc_d;
    logic        src_bios_q;
    logic        valid_q;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;
    logic        advance;

    // While invalid (first cycle after reset) re-fetch pc_f so that
    // the first delivered instruction is the one at RESET_PC.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (rst_i) begin
            pc_d = RESET_PC;
        end else if (redirect_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (stall_i || !valid_q) begin
            pc_d = pc_q;
        end
    end

    assign advance = valid_q && (!stall_i || redirect_i);

    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            err_d = 1'b1;
        end
        if (advance) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            src_bios_q <= RESET_PC[30];
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            src_bios_q <= pc_d[30];
            valid_q    <= 1'b1;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bios_addr_o    = pc_d[13:2];
    assign imem_addr_o    = pc_d[15:2];
    assign pc_o           = pc_q;
    assign inst_valid_o   = valid_q;
    assign misalign_err_o = err_q;
    assign fetch_cnt_o    = cnt_q;
    assign inst_o         = !valid_q   ? NOP_INST :
                            src_bios_q ? bios_dout_i : imem_dout_i;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with synchronous memory models and
// an expected-result queue popped after every clock edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic [11:0] bios_addr;
    logic [31:0] bios_dout;
    logic [13:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] inst, pc, fetch_cnt;
    logic        inst_valid, misalign_err;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    fetch_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .bios_addr_o   (bios_addr),
        .bios_dout_i   (bios_dout),
        .imem_addr_o   (imem_addr),
        .imem_dout_i   (imem_dout),
        .inst_o        (inst),
        .pc_o          (pc),
        .inst_valid_o  (inst_valid),
        .misalign_err_o(misalign_err),
        .fetch_cnt_o   (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Word contents encode source and word index.
    always @(posedge clk) begin
        bios_dout <= 32'hB000_0000 | {20'd0, bios_addr};
        imem_dout <= 32'hA000_0000 | {18'd0, imem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] e_pc, input logic [31:0] e_inst,
                       input logic e_v, input logic e_err,
                       input logic [31:0] e_cnt);
        exp_t e;
        exp_t g;
        e.pc = e_pc;
        e.inst = e_inst;
        e.valid = e_v;
        e.err = e_err;
        e.cnt = e_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("pc", pc, g.pc);
        chk("inst", inst, g.inst);
        chk("valid", {31'd0, inst_valid}, {31'd0, g.valid});
        chk("misalign", {31'd0, misalign_err}, {31'd0, g.err});
        chk("fetch_cnt", fetch_cnt, g.cnt);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        #2;
        chk("bios_addr_rst", {20'd0, bios_addr}, 32'd0);
        chk("imem_addr_rst", {18'd0, imem_addr}, 32'd0);
        cyc(32'h4000_0000, NOP, 1'b0, 1'b0, 32'd0);
        cyc(32'h4000_0000, NOP, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        cyc(32'h4000_0000, 32'hB000_0000, 1'b1, 1'b0, 32'd0);
        cyc(32'h4000_0004, 32'hB000_0001, 1'b1, 1'b0, 32'd1);
        stall = 1'b1;
        repeat (3) cyc(32'h4000_0004, 32'hB000_0001, 1'b1, 1'b0, 32'd1);
        stall = 1'b0;
        cyc(32'h4000_0008, 32'hB000_0002, 1'b1, 1'b0, 32'd2);
        redirect = 1'b1;
        redirect_pc = 32'h1000_0010;
        cyc(32'h1000_0010, 32'hA000_0004, 1'b1, 1'b0, 32'd3);
        redirect = 1'b0;
        cyc(32'h1000_0014, 32'hA000_0005, 1'b1, 1'b0, 32'd4);
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h4000_0100;
        cyc(32'h4000_0100, 32'hB000_0040, 1'b1, 1'b0, 32'd5);
        redirect = 1'b0;
        cyc(32'h4000_0100, 32'hB000_0040, 1'b1, 1'b0, 32'd5);
        stall = 1'b0;
        cyc(32'h4000_0104, 32'hB000_0041, 1'b1, 1'b0, 32'd6);
        redirect = 1'b1;
        redirect_pc = 32'h1000_0006;
        cyc(32'h1000_0004, 32'hA000_0001, 1'b1, 1'b1, 32'd7);
        redirect = 1'b0;
        cyc(32'h1000_0008, 32'hA000_0002, 1'b1, 1'b1, 32'd8);
        redirect = 1'b1;
        redirect_pc = 32'h1000_0020;
        cyc(32'h1000_0020, 32'hA000_0008, 1'b1, 1'b1, 32'd9);
        redirect = 1'b0;
        stall = 1'b1;
        cyc(32'h1000_0020, 32'hA000_0008, 1'b1, 1'b1, 32'd9);
        rst = 1'b1;
        cyc(32'h4000_0000, NOP, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        stall = 1'b0;
        cyc(32'h4000_0000, 32'hB000_0000, 1'b1, 1'b0, 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc(32'hFFFF_FFFC, 32'hB000_0FFF, 1'b1, 1'b0, 32'd1);
        redirect = 1'b0;
        cyc(32'h0000_0000, 32'hA000_0000, 1'b1, 1'b0, 32'd2);
        redirect = 1'b1;
        redirect_pc = 32'hBFFF_FFF4;
        cyc(32'hBFFF_FFF4, 32'hA000_3FFD, 1'b1, 1'b0, 32'd3);
        redirect = 1'b0;
        cyc(32'hBFFF_FFF8, 32'hA000_3FFE, 1'b1, 1'b0, 32'd4);
        cyc(32'hBFFF_FFFC, 32'hA000_3FFF, 1'b1, 1'b0, 32'd5);
        cyc(32'hC000_0000, 32'hB000_0000, 1'b1, 1'b0, 32'd6);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h4000_0000, PC loaded on reset (BIOS base).
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), instruction presented when output invalid.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 stall  input  1  hold current fetch and decode-facing outputs.
REQ-006 redirect  input  1  taken branch/jump; load redirect_pc.
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 bios_addr  output  12  BIOS word address, equal to next_pc[13:2].
REQ-009 bios_dout  input  32  BIOS read data, one-cycle synchronous read.
REQ-010 imem_addr  output  14  IMEM word address, equal to next_pc[15:2].
REQ-011 imem_dout  input  32  IMEM read data, one-cycle synchronous read.
REQ-012 inst  output  32  instruction to decode (instruction decoder input).
REQ-013 pc  output  32  address of inst.
REQ-014 inst_valid  output  1  inst/pc hold a real fetched instruction.
REQ-015 misalign_err  output  1  sticky flag, a redirect target had bits [1:0] nonzero.
REQ-016 fetch_cnt  output  32  count of valid instructions delivered.

Function
REQ-017 SHALL compute next_pc combinationally with priority rst > redirect > stall > sequential: RESET_PC, {redirect_pc[31:2],2'b00}, pc_f, pc_f+4.
REQ-018 SHALL register pc_f <= next_pc every cycle; pc SHALL equal pc_f.
REQ-019 SHALL drive both bios_addr and imem_addr from next_pc every cycle so the memory word for pc_f is on *_dout the cycle after.
REQ-020 SHALL register src_bios <= next_pc[30] every cycle; inst selects bios_dout when src_bios=1, else imem_dout.
REQ-021 SHALL produce inst = NOP_INST whenever inst_valid=0.
REQ-022 SHALL add no bubble on redirect: cycle after redirect, pc = target and inst = target's word with inst_valid=1; the instruction shown during the redirect cycle is the consumer's to kill.
REQ-023 SHALL, on stall without redirect, keep pc, inst, inst_valid unchanged next cycle (same address re-read).
REQ-024 SHALL let redirect override a simultaneous stall.
REQ-025 SHALL compute pc_f+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000, no flag).
REQ-026 SHALL set misalign_err on any cycle with redirect=1 and redirect_pc[1:0]!=0; cleared only by rst; fetch still proceeds to the word-aligned address.
REQ-027 SHALL increment fetch_cnt by 1 on each rising edge where inst_valid=1 and stall=0 (redirect cycles included); wrap at 2^32.
REQ-028 SHALL treat addresses with pc[30]=0 as IMEM regardless of other high bits.

Reset
REQ-029 SHALL, while rst=1 at an edge: pc_f <= RESET_PC, src_bios <= RESET_PC[30], inst_valid <= 0, misalign_err <= 0, fetch_cnt <= 0.
REQ-030 SHALL drive bios_addr/imem_addr from RESET_PC during reset cycles.
REQ-031 SHALL set inst_valid <= 1 on the first edge with rst=0 and hold it 1 until next reset; first valid output is pc=RESET_PC+4? No: pc=RESET_PC, inst=bios word 0.
REQ-032 SHALL let rst asserted mid-stall or mid-redirect override both in the same edge.

Verification
REQ-033 Reset release, no stall: pc sequence 0x4000_0000, 0x4000_0004, 0x4000_0008; inst_valid 0 during reset, 1 from first post-reset cycle; inst = BIOS words 0,1,2; fetch_cnt 0,1,2.
REQ-034 Redirect to 0x1000_0010 at pc=0x4000_0008: next cycle pc=0x1000_0010, inst = IMEM word 4, src switches to IMEM, no NOP bubble.
REQ-035 Stall 3 cycles at pc=0x4000_0004: pc and inst frozen, fetch_cnt frozen; resumes at 0x4000_0008 on release.
REQ-036 Stall and redirect to 0x4000_0100 same cycle: next pc=0x4000_0100, fetch_cnt +1.
REQ-037 Redirect to 0x1000_0006: misalign_err=1 next cycle and stays 1; pc=0x1000_0004.
REQ-038 rst pulsed during active stall at pc=0x1000_0020: next cycle pc=0x4000_0000, inst=NOP_INST, inst_valid=0, fetch_cnt=0, misalign_err=0.
